// File: rtl/bcd_adder_if.sv
// Operand/result bundle for bcd_adder: the requester drives operands, the adder
// returns the registered sum, carry, error flag and a one-cycle valid pulse.
interface bcd_adder_if #(
  parameter int DIGITS = 1
);
  logic                  in_valid;
  logic [4*DIGITS-1:0]   A;
  logic [4*DIGITS-1:0]   B;
  logic                  Cin;
  logic [4*DIGITS-1:0]   S;
  logic                  Cout;
  logic                  out_valid;
  logic                  err;

  modport master (
    output in_valid, A, B, Cin,
    input  S, Cout, out_valid, err
  );

  modport slave (
    input  in_valid, A, B, Cin,
    output S, Cout, out_valid, err
  );
endinterface

// File: rtl/bcd_adder.sv
// Registered packed-BCD adder: digit-serial ripple with +6 decimal correction,
// one cycle from operand acceptance to result, non-BCD input digits flagged.
module bcd_adder #(
  parameter int DIGITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  bcd_adder_if.slave bus
);

  logic [4*DIGITS-1:0] sum_c;
  logic                cout_c;
  logic                err_c;
  logic                carry;
  logic [3:0]          a_d;
  logic [3:0]          b_d;
  logic [4:0]          raw;

  // NOTE: every variable gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sum_c  = '0;
    carry  = bus.Cin;
    err_c  = 1'b0;
    a_d    = '0;
    b_d    = '0;
    raw    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      a_d = bus.A[4*i +: 4];
      b_d = bus.B[4*i +: 4];
      raw = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, carry};
      // Correction applies even to non-BCD digits so the result stays deterministic.
      if (raw > 5'd9) begin
        sum_c[4*i +: 4] = 4'(raw + 5'd6);
        carry           = 1'b1;
      end else begin
        sum_c[4*i +: 4] = raw[3:0];
        carry           = 1'b0;
      end
      if ((a_d > 4'd9) || (b_d > 4'd9)) begin
        err_c = 1'b1;
      end
    end
    cout_c = carry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.S         <= '0;
      bus.Cout      <= 1'b0;
      bus.err       <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.S    <= sum_c;
        bus.Cout <= cout_c;
        bus.err  <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_bcd_adder.sv
// Self-checking bench for bcd_adder: 1-digit and 4-digit instances, a decimal
// reference model compared every cycle, plus hand-computed directed vectors.
module tb_bcd_adder;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        e;
  } res_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   armed    = 1'b0;

  bcd_adder_if #(.DIGITS(1)) if1 ();
  bcd_adder_if #(.DIGITS(4)) if4 ();

  bcd_adder #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  bcd_adder #(.DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Valid BCD goes through plain decimal integer arithmetic; any non-BCD
  // digit falls back to the per-digit correction rule.
  function automatic res_t model(input int digits, input logic [31:0] a,
                                 input logic [31:0] b, input logic cin);
    res_t    r;
    bit      bad = 1'b0;
    longint  av = 0, bv = 0, p = 1, tot;
    int      da, db, raw, c;
    for (int i = 0; i < digits; i++) begin
      da = int'(a[4*i +: 4]);
      db = int'(b[4*i +: 4]);
      if (da > 9 || db > 9) bad = 1'b1;
      av += da * p;
      bv += db * p;
      p  *= 10;
    end
    r.e = bad;
    r.s = '0;
    if (!bad) begin
      tot  = av + bv + (cin ? 1 : 0);
      r.co = (tot >= p);
      tot  = tot % p;
      for (int i = 0; i < digits; i++) begin
        r.s[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end else begin
      c = cin ? 1 : 0;
      for (int i = 0; i < digits; i++) begin
        raw = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
        if (raw > 9) begin
          r.s[4*i +: 4] = 4'((raw + 6) % 16);
          c = 1;
        end else begin
          r.s[4*i +: 4] = 4'(raw);
          c = 0;
        end
      end
      r.co = (c != 0);
    end
    return r;
  endfunction

  // Reference registers: what the outputs must hold after each edge.
  logic [31:0] m1_s,  m4_s;
  logic        m1_co, m4_co, m1_e, m4_e, m1_ov, m4_ov;

  always @(posedge clk) begin
    res_t r1, r4;
    r1 = model(1, 32'(if1.A), 32'(if1.B), if1.Cin);
    r4 = model(4, 32'(if4.A), 32'(if4.B), if4.Cin);
    if (rst) begin
      m1_s <= '0; m1_co <= 1'b0; m1_e <= 1'b0; m1_ov <= 1'b0;
      m4_s <= '0; m4_co <= 1'b0; m4_e <= 1'b0; m4_ov <= 1'b0;
    end else begin
      m1_ov <= if1.in_valid;
      m4_ov <= if4.in_valid;
      if (if1.in_valid) begin
        m1_s <= r1.s; m1_co <= r1.co; m1_e <= r1.e;
      end
      if (if4.in_valid) begin
        m4_s <= r4.s; m4_co <= r4.co; m4_e <= r4.e;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("m1_out_valid", 32'(if1.out_valid), 32'(m1_ov));
      check("m1_S",         32'(if1.S),         m1_s);
      check("m1_Cout",      32'(if1.Cout),      32'(m1_co));
      check("m1_err",       32'(if1.err),       32'(m1_e));
      check("m4_out_valid", 32'(if4.out_valid), 32'(m4_ov));
      check("m4_S",         32'(if4.S),         m4_s);
      check("m4_Cout",      32'(if4.Cout),      32'(m4_co));
      check("m4_err",       32'(if4.err),       32'(m4_e));
    end
  end

  task automatic idle1();
    if1.in_valid = 1'b0; if1.A = 4'h7; if1.B = 4'h8; if1.Cin = 1'b1;
  endtask

  task automatic idle4();
    if4.in_valid = 1'b0; if4.A = 16'h4321; if4.B = 16'h1111; if4.Cin = 1'b0;
  endtask

  task automatic step1(input string name, input logic [3:0] a, input logic [3:0] b,
                       input logic cin, input logic [3:0] es, input logic ec,
                       input logic ee);
    if1.in_valid = 1'b1; if1.A = a; if1.B = b; if1.Cin = cin;
    @(negedge clk);
    check({name, "_ov"},   32'(if1.out_valid), 32'd1);
    check({name, "_S"},    32'(if1.S),         32'(es));
    check({name, "_Cout"}, 32'(if1.Cout),      32'(ec));
    check({name, "_err"},  32'(if1.err),       32'(ee));
  endtask

  task automatic step4(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [15:0] es, input logic ec,
                       input logic ee);
    if4.in_valid = 1'b1; if4.A = a; if4.B = b; if4.Cin = cin;
    @(negedge clk);
    check({name, "_ov"},   32'(if4.out_valid), 32'd1);
    check({name, "_S"},    32'(if4.S),         32'(es));
    check({name, "_Cout"}, 32'(if4.Cout),      32'(ec));
    check({name, "_err"},  32'(if4.err),       32'(ee));
  endtask

  initial begin
    rst = 1'b1;
    idle1();
    idle4();
    @(negedge clk);
    armed = 1'b1;
    @(negedge clk);
    check("rst_S",    32'(if1.S),         32'd0);
    check("rst_Cout", 32'(if1.Cout),      32'd0);
    check("rst_ov",   32'(if1.out_valid), 32'd0);
    check("rst_err",  32'(if1.err),       32'd0);
    check("rst4_S",   32'(if4.S),         32'd0);
    rst = 1'b0;

    step1("v1_1p1",   4'd1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0);
    step1("v2_5p1",   4'd5, 4'd1, 1'b0, 4'd6, 1'b0, 1'b0);
    step1("v3_5p1c",  4'd5, 4'd1, 1'b1, 4'd7, 1'b0, 1'b0);
    step1("v4_9p1",   4'd9, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0);
    step1("v5_6p6",   4'd6, 4'd6, 1'b0, 4'd2, 1'b1, 1'b0);
    step1("b_0p0",    4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    step1("b_9p0c",   4'd9, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0);
    step1("b_9p9c",   4'd9, 4'd9, 1'b1, 4'd9, 1'b1, 1'b0);

    idle1();
    repeat (2) begin
      @(negedge clk);
      check("hold_ov",   32'(if1.out_valid), 32'd0);
      check("hold_S",    32'(if1.S),         32'd9);
      check("hold_Cout", 32'(if1.Cout),      32'd1);
    end

    step1("nb_Cp1",   4'hC, 4'd1, 1'b0, 4'd3, 1'b1, 1'b1);
    step1("nb_2p3",   4'd2, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0);
    idle1();

    step4("m_9999",   16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    step4("m_1234",   16'h1234, 16'h5678, 1'b1, 16'h6913, 1'b0, 1'b0);
    step4("m_nonbcd", 16'h1A23, 16'h0101, 1'b0, 16'h2124, 1'b0, 1'b1);
    step4("m_0999c",  16'h0999, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);
    idle4();
    @(negedge clk);

    // Operands presented during reset must be dropped.
    rst = 1'b1;
    if1.in_valid = 1'b1; if1.A = 4'd5; if1.B = 4'd5; if1.Cin = 1'b0;
    @(negedge clk);
    check("rstpri_S",    32'(if1.S),         32'd0);
    check("rstpri_Cout", 32'(if1.Cout),      32'd0);
    check("rstpri_ov",   32'(if1.out_valid), 32'd0);
    rst = 1'b0;

    step1("mid_3p4",  4'd3, 4'd4, 1'b0, 4'd7, 1'b0, 1'b0);
    rst = 1'b1;
    if1.A = 4'd2; if1.B = 4'd2;
    @(negedge clk);
    check("mid_rst_S",  32'(if1.S),         32'd0);
    check("mid_rst_ov", 32'(if1.out_valid), 32'd0);
    rst = 1'b0;

    for (int a = 0; a < 10; a++) begin
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < 2; c++) begin
          if1.in_valid = 1'b1; if1.A = 4'(a); if1.B = 4'(b); if1.Cin = 1'(c);
          @(negedge clk);
          check("exh_sum", 32'(int'(if1.S) + 10 * int'(if1.Cout)), 32'(a + b + c));
          check("exh_err", 32'(if1.err), 32'd0);
        end
      end
    end
    idle1();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
